// File: rtl/frame_buffer_unit_if.sv
// Frame-buffer bus: pixel write/draw request from the sprite controller plus the
// valid/ready pixel stream toward the display.
interface frame_buffer_unit_if #(
    parameter int PX_W    = 16,
    parameter int COLOR_W = 8
);
    logic               fb_wfb;
    logic [PX_W-1:0]    fb_px;
    logic [COLOR_W-1:0] fb_r;
    logic [COLOR_W-1:0] fb_g;
    logic [COLOR_W-1:0] fb_b;
    logic               fb_dfb;
    logic               fb_busy;
    logic               disp_valid;
    logic               disp_ready;
    logic [PX_W-1:0]    disp_px;
    logic [COLOR_W-1:0] disp_r;
    logic [COLOR_W-1:0] disp_g;
    logic [COLOR_W-1:0] disp_b;
    logic               disp_last;

    modport master (
        output fb_wfb, fb_px, fb_r, fb_g, fb_b, fb_dfb, disp_ready,
        input  fb_busy, disp_valid, disp_px, disp_r, disp_g, disp_b, disp_last
    );

    modport slave (
        input  fb_wfb, fb_px, fb_r, fb_g, fb_b, fb_dfb, disp_ready,
        output fb_busy, disp_valid, disp_px, disp_r, disp_g, disp_b, disp_last
    );
endinterface

// File: rtl/frame_buffer_unit.sv
// 2^PX_W-pixel RGB frame store: single-pixel writes at any time, and a draw
// request streams the full frame out in index order over valid/ready.
module frame_buffer_unit #(
    parameter int PX_W    = 16,
    parameter int COLOR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    frame_buffer_unit_if.slave bus
);
    localparam int              DEPTH    = 1 << PX_W;
    localparam int              DW       = 3 * COLOR_W;
    localparam logic [PX_W-1:0] LAST_IDX = {PX_W{1'b1}};
    localparam logic [PX_W-1:0] ZERO_IDX = {PX_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    logic [DW-1:0]   mem_q [DEPTH];
    state_e          state_q;
    logic [PX_W-1:0] rd_ptr_q;
    logic            all_loaded_q;
    logic            valid_q;
    logic            last_q;
    logic [PX_W-1:0] px_q;
    logic [DW-1:0]   rgb_q;
    logic            load_s;
    logic            done_s;

    // A beat is loaded when the output register is free or being drained.
    assign load_s = (!valid_q || bus.disp_ready) && !all_loaded_q;
    assign done_s = valid_q && bus.disp_ready && last_q;

    // Pixel write port; memory has no reset and writes land in every state.
    always_ff @(posedge clk_i) begin
        if (bus.fb_wfb) begin
            mem_q[bus.fb_px] <= {bus.fb_r, bus.fb_g, bus.fb_b};
        end
    end

    // Scan FSM; the output register doubles as the registered read port, so a
    // same-edge write to the loaded address is seen as old data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            rd_ptr_q     <= ZERO_IDX;
            all_loaded_q <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            px_q         <= ZERO_IDX;
            rgb_q        <= {DW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.fb_dfb) begin
                        // Pixel 0 is fetched on the request edge itself.
                        state_q      <= ST_SCAN;
                        rgb_q        <= mem_q[ZERO_IDX];
                        px_q         <= ZERO_IDX;
                        last_q       <= (ZERO_IDX == LAST_IDX);
                        all_loaded_q <= (ZERO_IDX == LAST_IDX);
                        valid_q      <= 1'b1;
                        rd_ptr_q     <= ZERO_IDX + PX_W'(1);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (done_s) begin
                        state_q      <= ST_IDLE;
                        valid_q      <= 1'b0;
                        last_q       <= 1'b0;
                        all_loaded_q <= 1'b0;
                        rd_ptr_q     <= ZERO_IDX;
                    end else if (load_s) begin
                        rgb_q        <= mem_q[rd_ptr_q];
                        px_q         <= rd_ptr_q;
                        last_q       <= (rd_ptr_q == LAST_IDX);
                        all_loaded_q <= (rd_ptr_q == LAST_IDX);
                        valid_q      <= 1'b1;
                        rd_ptr_q     <= rd_ptr_q + PX_W'(1);
                    end else begin
                        state_q <= ST_SCAN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fb_busy    = (state_q == ST_SCAN) || bus.fb_dfb;
    assign bus.disp_valid = valid_q;
    assign bus.disp_last  = last_q;
    assign bus.disp_px    = px_q;
    assign bus.disp_r     = rgb_q[DW-1 -: COLOR_W];
    assign bus.disp_g     = rgb_q[COLOR_W +: COLOR_W];
    assign bus.disp_b     = rgb_q[COLOR_W-1:0];
endmodule

// File: tb/tb_frame_buffer_unit.sv
// Directed bench for frame_buffer_unit: full-frame timing, write visibility,
// wrapped-x block, ignored redraw, random backpressure and mid-scan reset.
module tb_frame_buffer_unit;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [23:0] model [int];
    logic [23:0] px10_new;
    logic [23:0] held_rgb;
    logic        stalled;
    int          idx;
    int          cyc;

    frame_buffer_unit_if #(.PX_W(16), .COLOR_W(8)) bus_if ();

    frame_buffer_unit #(.PX_W(16), .COLOR_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int p, input logic [23:0] rgb);
        bus_if.fb_wfb = 1'b1;
        bus_if.fb_px  = 16'(p);
        {bus_if.fb_r, bus_if.fb_g, bus_if.fb_b} = rgb;
        model[p] = rgb;
        @(negedge clk);
        bus_if.fb_wfb = 1'b0;
    endtask

    function automatic logic [23:0] obs_rgb();
        return {bus_if.disp_r, bus_if.disp_g, bus_if.disp_b};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        px10_new = 24'h0F1E2D;
        rst = 1'b1;
        bus_if.fb_wfb = 1'b0;
        bus_if.fb_px  = 16'd0;
        bus_if.fb_r   = 8'd0;
        bus_if.fb_g   = 8'd0;
        bus_if.fb_b   = 8'd0;
        bus_if.fb_dfb = 1'b0;
        bus_if.disp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(bus_if.fb_busy), 32'd0);
        chk("rst_valid", 32'(bus_if.disp_valid), 32'd0);
        chk("rst_last", 32'(bus_if.disp_last), 32'd0);
        chk("rst_px", 32'(bus_if.disp_px), 32'd0);
        chk("rst_rgb", 32'(obs_rgb()), 32'd0);

        // Neighbours of the block, then the 8x8 block at x=250 (x wraps past 255).
        wr(250, 24'h0A0B0C);
        wr(505, 24'h111111);
        wr(258, 24'h222222);
        wr(2554, 24'h333333);
        for (int dy = 0; dy < 8; dy++) begin
            for (int dx = 0; dx < 8; dx++) begin
                wr(((1 + dy) << 8) | ((250 + dx) & 255),
                   {8'(dy * 8 + dx), 8'hA5, 8'(dx * 16 + dy)});
            end
        end
        wr(10, 24'h101010);
        wr(60000, 24'h606060);
        wr(0, 24'hFFFFFF);

        // Frame A, ready held high: pixel k valid in cycle N+1+k.
        bus_if.fb_dfb = 1'b1;
        #1 chk("a_busy_req", 32'(bus_if.fb_busy), 32'd1);
        for (int k = 0; k < 65536; k++) begin
            @(negedge clk);
            bus_if.fb_dfb = 1'b0;
            chk("a_valid", 32'(bus_if.disp_valid), 32'd1);
            chk("a_px", 32'(bus_if.disp_px), 32'(k));
            chk("a_last", 32'(bus_if.disp_last), 32'(k == 65535));
            chk("a_busy", 32'(bus_if.fb_busy), 32'd1);
            if (model.exists(k)) chk("a_rgb", 32'(obs_rgb()), 32'(model[k]));
            if (k == 1000) begin
                bus_if.fb_dfb = 1'b1;
                bus_if.fb_wfb = 1'b1;
                bus_if.fb_px  = 16'd60000;
                {bus_if.fb_r, bus_if.fb_g, bus_if.fb_b} = 24'hC0FFEE;
                model[60000] = 24'hC0FFEE;
            end else if (k == 1001) begin
                bus_if.fb_px  = 16'd10;
                {bus_if.fb_r, bus_if.fb_g, bus_if.fb_b} = px10_new;
            end else if (k == 1002) begin
                bus_if.fb_wfb = 1'b0;
            end
        end
        model[10] = px10_new;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("a_end_busy", 32'(bus_if.fb_busy), 32'd0);
            chk("a_end_valid", 32'(bus_if.disp_valid), 32'd0);
            chk("a_end_last", 32'(bus_if.disp_last), 32'd0);
        end

        // Frame B with random backpressure, abandoned by reset at pixel 500.
        bus_if.fb_dfb = 1'b1;
        #1 chk("b_busy_req", 32'(bus_if.fb_busy), 32'd1);
        @(negedge clk);
        bus_if.fb_dfb = 1'b0;
        idx = 0;
        cyc = 0;
        stalled = 1'b0;
        held_rgb = 24'd0;
        while (idx < 500 && cyc < 5000) begin
            chk("b_valid", 32'(bus_if.disp_valid), 32'd1);
            chk("b_px", 32'(bus_if.disp_px), 32'(idx));
            chk("b_last", 32'(bus_if.disp_last), 32'd0);
            if (stalled) chk("b_hold_rgb", 32'(obs_rgb()), 32'(held_rgb));
            if (model.exists(idx)) chk("b_rgb", 32'(obs_rgb()), 32'(model[idx]));
            bus_if.disp_ready = 1'($urandom_range(0, 1));
            held_rgb = obs_rgb();
            stalled = !bus_if.disp_ready;
            if (bus_if.disp_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        chk("b_reached_500", 32'(idx), 32'd500);
        chk("b_px500", 32'(bus_if.disp_px), 32'd500);
        rst = 1'b1;
        wr(5, 24'h050505);
        rst = 1'b0;
        chk("rst_mid_valid", 32'(bus_if.disp_valid), 32'd0);
        chk("rst_mid_busy", 32'(bus_if.fb_busy), 32'd0);

        // Frame C restarts at pixel 0 with memory preserved.
        bus_if.disp_ready = 1'b1;
        bus_if.fb_dfb = 1'b1;
        #1 chk("c_busy_req", 32'(bus_if.fb_busy), 32'd1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus_if.fb_dfb = 1'b0;
            chk("c_valid", 32'(bus_if.disp_valid), 32'd1);
            chk("c_px", 32'(bus_if.disp_px), 32'(k));
            if (model.exists(k)) chk("c_rgb", 32'(obs_rgb()), 32'(model[k]));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("c_rst_valid", 32'(bus_if.disp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frame_buffer_unit.md
# frame_buffer_unit

Pixel store on the receiving end of the sprite command controller's frame-buffer interface. It accepts single-pixel writes (`fb_wfb`) into a 256x256 24-bit RGB memory and, on a draw request (`fb_dfb`), streams the whole frame out to the display side over a valid/ready interface. While a frame is streaming it holds `fb_busy` high so the controller stalls further draw requests.

## Interface
Parameters:
- `PX_W`, 16: pixel index width; frame holds 2^PX_W pixels, index = {y[7:0], x[7:0]}.
- `COLOR_W`, 8: width of each colour channel.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `fb_wfb`  in  1  write strobe, one pixel per asserted cycle.
- `fb_px`  in  PX_W  write pixel index.
- `fb_r`, `fb_g`, `fb_b`  in  COLOR_W each  write colour.
- `fb_dfb`  in  1  draw-frame request, single-cycle pulse.
- `fb_busy`  out  1  high while a draw request is being taken or a frame is streaming.
- `disp_valid`  out  1  output pixel valid.
- `disp_ready`  in  1  display sink accepts the pixel this cycle.
- `disp_px`  out  PX_W  index of the output pixel.
- `disp_r`, `disp_g`, `disp_b`  out  COLOR_W each  output colour.
- `disp_last`  out  1  high with pixel 2^PX_W-1.

## Operation
- Memory: 2^PX_W x 3*COLOR_W. It has one write port and one registered read port. Contents are not cleared by `rst`.
- Write: on an edge with `fb_wfb`=1, mem[`fb_px`] <= {r,g,b}. Writes are accepted in every state, including SCAN.
- A write and a scan read to the same address in the same cycle return the old data (read-before-write).
- FSM states:
  - IDLE: `fb_busy` = `fb_dfb` (combinational). If `fb_dfb`=1, go to SCAN and set `rd_ptr` to 0.
  - SCAN: `fb_busy`=1. The output register is loaded from mem[`rd_ptr`] when it is empty or being consumed (`!disp_valid || disp_ready`). Each load increments `rd_ptr`. After index 2^PX_W-1 has been loaded, no further loads occur. When the pixel with `disp_last`=1 is accepted (`disp_valid && disp_ready`), go to IDLE.
- `fb_dfb` is ignored while in SCAN (no restart, no queuing).
- `disp_px` always equals the index the displayed data was read from. Pixels are output in strictly increasing order 0..2^PX_W-1 with no gaps or duplicates.
- Backpressure: while `disp_valid`=1 and `disp_ready`=0, `disp_px`, colour and `disp_last` hold stable, and `rd_ptr` does not advance.
- Index arithmetic is PX_W bits. `disp_last` is derived from the loaded index and does not depend on wrap of `rd_ptr`.

## Timing
- Reset values: `fb_busy`=0 (state IDLE), `disp_valid`=0, `disp_last`=0, `disp_px`=0, colour outputs 0, `rd_ptr`=0.
- `rst` asserted mid-scan: the next edge forces IDLE. `disp_valid` drops and the frame is abandoned. Any write on that edge still lands in memory.
- `fb_dfb` is sampled at edge N, with `fb_busy` already high during cycle N.
- With `disp_ready` held at 1:
  - pixel k is valid during cycle N+1+k;
  - `disp_last` is valid during cycle N+2^PX_W;
  - the FSM returns to IDLE at the edge ending that cycle, and `fb_busy` is 0 from cycle N+2^PX_W+1.
- Throughput is 1 pixel/cycle. Each cycle of `disp_ready`=0 with valid high adds exactly one cycle.
- A write to a pixel takes effect for any read issued at a later edge. It is visible in the current scan only if that pixel has not been loaded yet.

## Test plan
- Reset, then `fb_dfb` with `disp_ready`=1 -> `fb_busy`=1 in the request cycle; 65536 valid beats, `disp_px` 0..65535 consecutive; `disp_last` only on 65535; `fb_busy`=0 on the cycle after the last beat.
- `fb_wfb` px=0 RGB=FFFFFF, then `fb_dfb` next cycle -> beat 0 carries FFFFFF.
- Write an 8x8 block at x=250,y=1 with distinct values, then scan -> beats {y,x} for that block match; surrounding pixels keep prior data.
- Random `disp_ready` (about 50% low) during scan -> outputs stable while stalled; no drop or duplicate; total beats = 65536.
- `fb_dfb` pulsed at pixel 1000 of a scan -> ignored, frame ends at 65535 with no restart. A write to px 60000 during the scan at pixel 1000 -> appears in this frame. A write to px 10 at the same point -> appears only on the next frame.
- `rst` during the scan at pixel 500 -> `disp_valid`=0 and `fb_busy`=0 after the edge. A new `fb_dfb` then restarts at px 0 and memory contents are preserved.
